// File: rtl/sort_result_serializer_if.sv
// Handshake bundle between the sort unit, the serializer and the byte consumer.
// The slave modport is the serializer's view; master is the surrounding logic.
interface sort_result_serializer_if;
    logic [31:0] in_;
    logic        in_val;
    logic [7:0]  out;
    logic        out_val;
    logic        out_rdy;
    logic        overflow;
    logic        order_err;

    modport master (
        output in_, in_val, out_rdy,
        input  out, out_val, overflow, order_err
    );

    modport slave (
        input  in_, in_val, out_rdy,
        output out, out_val, overflow, order_err
    );
endinterface

// File: rtl/sort_result_serializer.sv
// Buffers sorted 4x8-bit words in a DEPTH-entry FIFO and streams them out bytewise, smallest first.
// Optional macro SORT_SERIALIZER_ORDER_CHECK_EN adds a sticky non-decreasing-order check on accepted words.
module sort_result_serializer #(
    parameter int DEPTH = 2
) (
    input logic                     clk,
    input logic                     reset,
    sort_result_serializer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [1:0]    r_idx;
    logic          r_overflow;

    logic          w_full;
    logic          w_out_val;
    logic          w_xfer;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [31:0]   w_head;
    logic [7:0]    w_byte;

    assign w_full    = (r_count == FULL_CNT);
    assign w_out_val = (r_count != '0);
    assign w_xfer    = w_out_val & bus.out_rdy;
    assign w_pop     = w_xfer & (r_idx == 2'd3);
    // A full FIFO still takes a word when the head's last byte leaves on the same edge.
    assign w_push    = bus.in_val & (~w_full | w_pop);
    assign w_drop    = bus.in_val & w_full & ~w_pop;
    assign w_head    = r_mem[r_rd_ptr];

    always_comb begin
        w_byte = 8'h00;
        if (w_out_val) begin
            case (r_idx)
                2'd0:    w_byte = w_head[31:24];
                2'd1:    w_byte = w_head[23:16];
                2'd2:    w_byte = w_head[15:8];
                default: w_byte = w_head[7:0];
            endcase
        end
    end

    assign bus.out      = w_byte;
    assign bus.out_val  = w_out_val;
    assign bus.overflow = r_overflow;

    // Storage is deliberately left out of reset; count gates everything read from it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_idx      <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ONE_PTR;
            end
            if (w_xfer) begin
                r_idx <= r_idx + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ONE_PTR;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_CNT;
                2'b01:   r_count <= r_count - ONE_CNT;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef SORT_SERIALIZER_ORDER_CHECK_EN
    logic w_order_bad;
    logic r_order_err;

    assign w_order_bad = ~((bus.in_[31:24] <= bus.in_[23:16]) &&
                           (bus.in_[23:16] <= bus.in_[15:8])  &&
                           (bus.in_[15:8]  <= bus.in_[7:0]));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_order_err <= 1'b0;
        end else if (w_push && w_order_bad) begin
            r_order_err <= 1'b1;
        end
    end

    assign bus.order_err = r_order_err;
`else
    assign bus.order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_result_serializer.sv
// Self-checking bench for sort_result_serializer: directed table, corner sequences,
// and randomized traffic against a word-queue reference model.
module tb_sort_result_serializer;
    localparam int DEPTH = 2;
`ifdef SORT_SERIALIZER_ORDER_CHECK_EN
    localparam bit ORD_EN = 1'b1;
`else
    localparam bit ORD_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    sort_result_serializer_if bus ();

    sort_result_serializer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        e_val;
        logic [7:0]  e_out;
        logic        e_ovf;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic v, input logic [31:0] d, input logic r);
        bus.in_val  = v;
        bus.in_     = d;
        bus.out_rdy = r;
        @(posedge clk);
        #1;
    endtask

    // Ends at a falling edge so the very next rising edge is the first after release.
    task automatic do_reset();
        reset       = 1'b0;
        bus.in_val  = 1'b0;
        bus.in_     = 32'h0;
        bus.out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_val", bus.out_val, 1'b0);
        chk("rst_out", bus.out, 8'h00);
        chk("rst_overflow", bus.overflow, 1'b0);
        chk("rst_order_err", bus.order_err, 1'b0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Bytes expected after a sequence of pushes with out_rdy held high.
    task automatic expect_bytes(input string name, input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int k = 0; k < 4; k++) begin
            chk({name, "_val"}, bus.out_val, 1'b1);
            chk(name, bus.out, t[31:24]);
            t = t << 8;
            cyc(1'b0, 32'h0, 1'b1);
        end
    endtask

    logic [31:0] mq [$];
    int          midx;
    bit          movf;
    bit          mord;

    initial begin
        logic [31:0] w;
        logic [7:0]  eb;
        logic        v;
        logic        r;
        bit          xfer;
        bit          pop;
        bit          full;
        int          pv;
        int          pr;

        n_tests = 0;
        n_fail  = 0;

        tbl[0]  = '{1'b1, 32'h031A5CF0, 1'b1, 1'b1, 8'h03, 1'b0};
        tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h1A, 1'b0};
        tbl[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h5C, 1'b0};
        tbl[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hF0, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0};
        tbl[5]  = '{1'b1, 32'h01020304, 1'b0, 1'b1, 8'h01, 1'b0};
        tbl[6]  = '{1'b1, 32'h05060708, 1'b0, 1'b1, 8'h01, 1'b0};
        tbl[7]  = '{1'b1, 32'h090A0B0C, 1'b0, 1'b1, 8'h01, 1'b1};
        tbl[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h02, 1'b1};
        tbl[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h03, 1'b1};
        tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h04, 1'b1};
        tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h05, 1'b1};
        tbl[12] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h06, 1'b1};
        tbl[13] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h07, 1'b1};
        tbl[14] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h08, 1'b1};
        tbl[15] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b1};

        // Basic serialization then overflow/drain from the table.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].r);
            chk("tbl_out_val", bus.out_val, tbl[i].e_val);
            if (tbl[i].e_val) chk("tbl_out", bus.out, tbl[i].e_out);
            chk("tbl_overflow", bus.overflow, tbl[i].e_ovf);
            chk("tbl_order_err", bus.order_err, 1'b0);
        end

        // Backpressure holds the first byte.
        do_reset();
        cyc(1'b1, 32'h031A5CF0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_val", bus.out_val, 1'b1);
            chk("bp_hold_out", bus.out, 8'h03);
            cyc(1'b0, 32'h0, 1'b0);
        end
        cyc(1'b0, 32'h0, 1'b1);
        chk("bp_out", bus.out, 8'h1A);
        cyc(1'b0, 32'h0, 1'b1);
        chk("bp_out", bus.out, 8'h5C);
        cyc(1'b0, 32'h0, 1'b1);
        chk("bp_out", bus.out, 8'hF0);
        cyc(1'b0, 32'h0, 1'b1);
        chk("bp_empty", bus.out_val, 1'b0);

        // Full FIFO accepts a word on the edge the head's last byte leaves.
        do_reset();
        cyc(1'b1, 32'h031A5CF0, 1'b0);
        cyc(1'b1, 32'h01020304, 1'b0);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("fp_last_byte", bus.out, 8'hF0);
        cyc(1'b1, 32'h11223344, 1'b1);
        chk("fp_overflow", bus.overflow, 1'b0);
        expect_bytes("fp_word2", 32'h01020304);
        expect_bytes("fp_word3", 32'h11223344);
        chk("fp_empty", bus.out_val, 1'b0);
        chk("fp_overflow_end", bus.overflow, 1'b0);

        // Reset mid-word discards everything.
        do_reset();
        cyc(1'b1, 32'h031A5CF0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("rmw_before", bus.out, 8'h1A);
        #2;
        reset = 1'b0;
        #1;
        chk("rmw_val_async", bus.out_val, 1'b0);
        chk("rmw_out_async", bus.out, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 32'h0, 1'b1);
            chk("rmw_after", bus.out_val, 1'b0);
        end

        // Order check on an unsorted word; the data path is unaffected.
        do_reset();
        cyc(1'b1, 32'h10052030, 1'b1);
        chk("ord_flag", bus.order_err, ORD_EN);
        expect_bytes("ord_bytes", 32'h10052030);
        chk("ord_empty", bus.out_val, 1'b0);
        chk("ord_sticky", bus.order_err, ORD_EN);

        // Randomized traffic against a word-queue model.
        do_reset();
        mq.delete();
        midx = 0;
        movf = 1'b0;
        mord = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (c == 400) begin
                do_reset();
                mq.delete();
                midx = 0;
                movf = 1'b0;
                mord = 1'b0;
            end
            pv = (c % 400 < 200) ? 20 : 60;
            pr = (c % 200 < 100) ? 85 : 40;
            v = ($urandom_range(99) < pv);
            r = ($urandom_range(99) < pr);
            w = $urandom;

            xfer = (mq.size() > 0) && r;
            pop  = xfer && (midx == 3);
            full = (mq.size() == DEPTH);
            if (xfer) begin
                midx = (midx + 1) % 4;
                if (pop) void'(mq.pop_front());
            end
            if (v && (!full || pop)) begin
                mq.push_back(w);
                if (!(w[31:24] <= w[23:16] && w[23:16] <= w[15:8] && w[15:8] <= w[7:0]))
                    mord = 1'b1;
            end else if (v) begin
                movf = 1'b1;
            end

            cyc(v, w, r);

            chk("rnd_out_val", bus.out_val, mq.size() > 0);
            if (mq.size() > 0) begin
                w  = mq[0];
                eb = w[31 - 8*midx -: 8];
                chk("rnd_out", bus.out, eb);
            end
            chk("rnd_overflow", bus.overflow, movf);
            chk("rnd_order_err", bus.order_err, ORD_EN && mord);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sort_result_serializer.md
SORT_RESULT_SERIALIZER -- requirements
Module: sort_result_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 2: number of 32-bit words buffered; power of two, >= 2.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_  input  32  sorted 4x8-bit word from the sort unit; element 0 (smallest) in [31:24], element 3 (largest) in [7:0].
REQ-005 SHALL have port in_val  input  1  in_ is valid this cycle; there is no ready, so the upstream cannot be stalled.
REQ-006 SHALL have port out  output  8  current element byte.
REQ-007 SHALL have port out_val  output  1  out is valid.
REQ-008 SHALL have port out_rdy  input  1  downstream accepts out this cycle.
REQ-009 SHALL have port overflow  output  1  sticky flag: a valid word was dropped.
REQ-010 SHALL have port order_err  output  1  sticky flag: a received word was not non-decreasing (ORDER_CHECK_EN only).

Function
REQ-011 SHALL store accepted words in a DEPTH-entry FIFO with write pointer, read pointer (each wrapping modulo DEPTH) and an occupancy count 0..DEPTH.
REQ-012 SHALL accept in_ at a clock edge when in_val=1 and the FIFO is not full, or when it is full and the head word's last byte transfers in that same cycle.
REQ-013 SHALL drop in_ and set overflow on the edge where in_val=1, the FIFO is full and no pop occurs; overflow stays 1 until reset.
REQ-014 SHALL drive out_val=1 exactly when count>0, and out = the head-word byte selected by a 2-bit index: index 0 gives [31:24] and index 3 gives [7:0].
REQ-015 SHALL count a transfer when out_val=1 and out_rdy=1; on a transfer the index increments; on a transfer at index 3 the index returns to 0 and the head word pops.
REQ-016 SHALL hold out and out_val stable while out_val=1 and out_rdy=0.
REQ-017 SHALL give latency: a word accepted into an empty FIFO at edge N presents its element 0 with out_val=1 in the cycle after edge N.
REQ-018 SHALL not present a word accepted at edge N before edge N, even when the FIFO was empty.
REQ-019 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-020 SHALL give a sustained throughput of one word per 4 cycles; an in_val rate above this fills the FIFO and then drops words.
REQ-021 SHALL ignore out_rdy while out_val=0.

Reset
REQ-022 SHALL, while reset=0, asynchronously clear count, both pointers, the index, overflow and order_err.
REQ-023 SHALL hold out_val=0 and out=8'h00 during reset; FIFO data storage is not reset.
REQ-024 SHALL, on reset assertion mid-word, discard the partially sent and all buffered words; no byte of them appears after release.
REQ-025 SHALL accept the first word on the first rising edge after reset deasserts.

Configuration
REQ-026 SHALL, with macro SORT_SERIALIZER_ORDER_CHECK_EN defined, compare every accepted word and set order_err on the accepting edge if any of [31:24]<=[23:16]<=[15:8]<=[7:0] fails, unsigned; the flag is sticky until reset.
REQ-027 SHALL, without SORT_SERIALIZER_ORDER_CHECK_EN, tie order_err to 0 and implement no comparators.
REQ-028 SHALL, in both modes, leave the data path, out and out_val unaffected by the order check.

Verification
REQ-029 SHALL cover basic serialization: reset, then in_=32'h03_1A_5C_F0 with in_val=1 for one cycle and out_rdy=1 held -> out = 03, 1A, 5C, F0 on 4 consecutive cycles starting the cycle after the push; then out_val=0.
REQ-030 SHALL cover backpressure: the same word with out_rdy=0 for 5 cycles after out_val rises -> out holds 03 with out_val=1; after out_rdy rises the remaining bytes follow in order with no loss.
REQ-031 SHALL cover overflow at DEPTH=2 with out_rdy=0: pushes 32'h01020304, 32'h05060708, 32'h090A0B0C -> overflow=1 after the 3rd push; with out_rdy=1 the output is 01..08, and 09..0C never appears.
REQ-032 SHALL cover full plus pop: with the FIFO full, push 32'h11223344 on the cycle the head byte index 3 transfers -> the word is accepted, overflow stays 0, and 11,22,33,44 appear after the buffered word.
REQ-033 SHALL cover reset mid-word: reset pulled low after byte 1A of 32'h031A5CF0 -> out_val=0 immediately; after release with no push, out_val stays 0.
REQ-034 SHALL cover the order check: with SORT_SERIALIZER_ORDER_CHECK_EN, push 32'h10_05_20_30 -> order_err=1 the cycle after the push and all four bytes still output; without the macro, order_err=0.
